stopwatch_counter: RTL and testbench

- Produces the four BCD stopwatch digits (STOPWATCH_3..STOPWATCH_0) consumed by the display-select mux.
- Counts elapsed MM:SS from a prescaled system clock.
- Controlled by start/stop, clear and lap button pulses; lap freezes the displayed value while counting continues.
- Buttons arrive already debounced and one-cycle pulsed from the button-conditioning stage.

---
 rtl/stopwatch_counter.sv | 169 ++++++++++++++++
 tb/tb_stopwatch_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with start/stop, clear and lap-freeze control.
// Digits are BCD; the lap register holds the frozen display value.
module stopwatch_counter #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       MODE_ACTIVE,
  input  logic       BTN_START_STOP,
  input  logic       BTN_CLEAR,
  input  logic       BTN_LAP,
  output logic [3:0] STOPWATCH_3,
  output logic [3:0] STOPWATCH_2,
  output logic [3:0] STOPWATCH_1,
  output logic [3:0] STOPWATCH_0,
  output logic       RUNNING,
  output logic       LAP_ACTIVE,
  output logic       OVF
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } mmss_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  mmss_t         cnt_q;
  mmss_t         cnt_d;
  mmss_t         cnt_inc;
  mmss_t         lap_q;
  mmss_t         lap_d;
  mmss_t         disp;
  logic          ovf_q;
  logic          ovf_d;
  logic          do_clear;
  logic          do_capture;
  logic          counting;
  logic          tick;
  logic          wrap;

  // Button decode: one pulse per cycle, CLEAR > START_STOP > LAP.
  always_comb begin
    state_d    = state_q;
    do_clear   = 1'b0;
    do_capture = 1'b0;
    if (MODE_ACTIVE) begin
      if (BTN_CLEAR) begin
        if (state_q == PAUSE) begin
          state_d  = IDLE;
          do_clear = 1'b1;
        end
      end else if (BTN_START_STOP) begin
        unique case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = PAUSE;
          LAP:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = IDLE;
        endcase
      end else if (BTN_LAP) begin
        unique case (state_q)
          RUN: begin
            state_d    = LAP;
            do_capture = 1'b1;
          end
          LAP:     state_d = RUN;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // One-second BCD increment with 59:59 -> 00:00 wrap detect.
  always_comb begin
    cnt_inc = cnt_q;
    wrap    = 1'b0;
    if (cnt_q.s1 < 4'd9) begin
      cnt_inc.s1 = cnt_q.s1 + 4'd1;
    end else begin
      cnt_inc.s1 = 4'd0;
      if (cnt_q.s10 < 4'd5) begin
        cnt_inc.s10 = cnt_q.s10 + 4'd1;
      end else begin
        cnt_inc.s10 = 4'd0;
        if (cnt_q.m1 < 4'd9) begin
          cnt_inc.m1 = cnt_q.m1 + 4'd1;
        end else begin
          cnt_inc.m1 = 4'd0;
          if (cnt_q.m10 < 4'd5) begin
            cnt_inc.m10 = cnt_q.m10 + 4'd1;
          end else begin
            cnt_inc.m10 = 4'd0;
            wrap        = 1'b1;
          end
        end
      end
    end
  end

  // Prescaler, count, lap and overflow next values.
  always_comb begin
    counting = (state_q == RUN) || (state_q == LAP);
    tick     = counting && (pre_q == PRE_MAX);
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    lap_d    = lap_q;
    ovf_d    = 1'b0;
    if (do_clear || (state_q == IDLE)) begin
      pre_d = '0;
    end else if (counting) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
    if (do_clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_inc;
      ovf_d = wrap;
    end
    if (do_capture) begin
      lap_d = cnt_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      lap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Display source: frozen lap value in LAP, live count otherwise.
  always_comb begin
    disp       = (state_q == LAP) ? lap_q : cnt_q;
    RUNNING    = (state_q == RUN) || (state_q == LAP);
    LAP_ACTIVE = (state_q == LAP);
  end

  assign STOPWATCH_3 = disp.m10;
  assign STOPWATCH_2 = disp.m1;
  assign STOPWATCH_1 = disp.s10;
  assign STOPWATCH_0 = disp.s1;
  assign OVF         = ovf_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with TICK_DIV = 4.
// Table rows pulse buttons on their first edge, then idle.
module tb_stopwatch_counter;

  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic       b_ss;
  logic       b_clr;
  logic       b_lap;
  logic [3:0] sw3, sw2, sw1, sw0;
  logic       running;
  logic       lap_active;
  logic       ovf;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        mode;
    logic        ss;
    logic        clr;
    logic        lap;
    int          cyc;
    logic [15:0] digits;
    logic        run;
    logic        lapa;
  } vec_t;

  vec_t tbl[$];

  stopwatch_counter #(.TICK_DIV(TD)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .MODE_ACTIVE(mode),
    .BTN_START_STOP(b_ss),
    .BTN_CLEAR(b_clr),
    .BTN_LAP(b_lap),
    .STOPWATCH_3(sw3),
    .STOPWATCH_2(sw2),
    .STOPWATCH_1(sw1),
    .STOPWATCH_0(sw0),
    .RUNNING(running),
    .LAP_ACTIVE(lap_active),
    .OVF(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic add(input string nm, input logic r, input logic m,
                     input logic ss, input logic clr, input logic lp,
                     input int cyc, input logic [15:0] dg,
                     input logic rn, input logic la);
    vec_t v;
    v.name = nm; v.rst_n = r; v.mode = m;
    v.ss = ss; v.clr = clr; v.lap = lp; v.cyc = cyc;
    v.digits = dg; v.run = rn; v.lapa = la;
    tbl.push_back(v);
  endtask

  function automatic logic [15:0] digits();
    return {sw3, sw2, sw1, sw0};
  endfunction

  initial begin
    int ovf_cnt;
    int ovf_at;
    rst_n = 1'b0; mode = 1'b1;
    b_ss = 1'b0; b_clr = 1'b0; b_lap = 1'b0;

    //  name         rst md ss cl lp cyc digits   run lap
    add("reset",      0, 1, 0, 0, 0,  2, 16'h0000, 0, 0);
    add("run4s",      1, 1, 1, 0, 0, 17, 16'h0004, 1, 0);
    add("run10s",     1, 1, 0, 0, 0, 24, 16'h0010, 1, 0);
    add("lap_frz",    1, 1, 0, 0, 1, 13, 16'h0010, 1, 1);
    add("lap_rel",    1, 1, 0, 0, 1,  1, 16'h0013, 1, 0);
    add("clr_run",    1, 1, 0, 1, 0,  1, 16'h0013, 1, 0);
    add("clr_run2",   1, 1, 0, 0, 0,  1, 16'h0014, 1, 0);
    add("reset2",     0, 1, 0, 0, 0,  1, 16'h0000, 0, 0);
    add("start2",     1, 1, 1, 0, 0,  1, 16'h0000, 1, 0);
    add("run5s_p2",   1, 1, 0, 0, 0, 22, 16'h0005, 1, 0);
    add("pause",      1, 1, 1, 0, 0,  1, 16'h0005, 0, 0);
    add("pause_hold", 1, 1, 0, 0, 0, 20, 16'h0005, 0, 0);
    add("resume",     1, 1, 1, 0, 0,  1, 16'h0005, 1, 0);
    add("resume_tk",  1, 1, 0, 0, 0,  1, 16'h0006, 1, 0);
    add("pause2",     1, 1, 1, 0, 0,  1, 16'h0006, 0, 0);
    add("clr_ss",     1, 1, 1, 1, 0,  1, 16'h0000, 0, 0);
    add("idle_hold",  1, 1, 0, 0, 0,  8, 16'h0000, 0, 0);
    add("start3",     1, 1, 1, 0, 0,  1, 16'h0000, 1, 0);
    add("pre_zero",   1, 1, 0, 0, 0,  3, 16'h0000, 1, 0);
    add("pre_tick",   1, 1, 0, 0, 0,  1, 16'h0001, 1, 0);
    add("mode0_ss",   0, 0, 1, 0, 0,  0, 16'h0000, 0, 0);
    add("mode0_run",  1, 0, 0, 0, 0,  3, 16'h0002, 1, 0);
    add("mode0_lap",  1, 0, 0, 0, 1,  1, 16'h0002, 1, 0);
    add("lap_on",     1, 1, 0, 0, 1,  1, 16'h0002, 1, 1);
    add("lap_bg",     1, 1, 0, 0, 0,  6, 16'h0002, 1, 1);
    add("rst_lap",    0, 1, 0, 0, 0,  1, 16'h0000, 0, 0);
    add("idle_lap",   1, 1, 0, 0, 1,  1, 16'h0000, 0, 0);
    add("start4",     1, 1, 1, 0, 0,  1, 16'h0000, 1, 0);
    add("lap4",       1, 1, 0, 0, 1,  1, 16'h0000, 1, 1);
    add("lap_ss",     1, 1, 1, 0, 0,  1, 16'h0000, 0, 0);

    // The mode0_ss row is rewritten in place: pulse with mode low.
    tbl[20].rst_n = 1'b1; tbl[20].cyc = 1;
    tbl[20].digits = 16'h0001; tbl[20].run = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n;
      mode  = tbl[i].mode;
      b_ss  = tbl[i].ss;
      b_clr = tbl[i].clr;
      b_lap = tbl[i].lap;
      step();
      b_ss = 1'b0; b_clr = 1'b0; b_lap = 1'b0;
      for (int c = 1; c < tbl[i].cyc; c++) step();
      check({tbl[i].name, ".digits"}, digits(), tbl[i].digits);
      check({tbl[i].name, ".running"}, 16'(running), 16'(tbl[i].run));
      check({tbl[i].name, ".lap"}, 16'(lap_active), 16'(tbl[i].lapa));
      check({tbl[i].name, ".ovf"}, 16'(ovf), 16'h0);
    end

    // Overflow: run to 59:58, then across the wrap.
    rst_n = 1'b0; mode = 1'b1;
    step();
    rst_n = 1'b1; b_ss = 1'b1;
    step();
    b_ss = 1'b0;
    for (int c = 0; c < 3598 * TD; c++) step();
    check("ovf.5958", digits(), 16'h5958);
    for (int c = 0; c < TD; c++) step();
    check("ovf.5959", digits(), 16'h5959);
    check("ovf.pre", 16'(ovf), 16'h0);
    ovf_cnt = 0;
    ovf_at  = -1;
    for (int c = 0; c < 2 * TD; c++) begin
      step();
      if (ovf === 1'b1) begin
        ovf_cnt++;
        ovf_at = c;
        check("ovf.wrap", digits(), 16'h0000);
      end
    end
    check("ovf.count", 16'(ovf_cnt), 16'd1);
    check("ovf.edge", 16'(ovf_at), 16'(TD - 1));
    check("ovf.after", digits(), 16'h0001);
    check("ovf.run", 16'(running), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
